stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Sequencing controller for the stopwatch `count` datapath. It synchronizes and debounces the raw pause/reset buttons and synchronizes the adjust/select switches. It generates one-cycle clock enables for normal counting (1 Hz), adjust stepping (2 Hz) and display digit scanning, and tracks the run/pause/adjust mode. All outputs are registered and sit between the board I/O and `count` plus the display driver.

## Interface
- `DIV_1HZ`, 100_000_000, `clk` cycles per `sec_tick`
- `DIV_2HZ`, 50_000_000, `clk` cycles per `adj_en`
- `DIV_SCAN`, 100_000, `clk` cycles per `scan` advance
- `DB_CYCLES`, 1_000_000, consecutive stable synchronized samples needed to accept a button level change
- `clk` in 1: sole clock; all logic on the rising edge
- `reset` in 1: synchronous, active-low block reset
- `btn_pause` in 1: raw pause button, asynchronous, bouncy
- `btn_rst` in 1: raw clear button, asynchronous, bouncy
- `adjust` in 2: raw adjust switches; nonzero selects adjust mode
- `select` in 1: raw switch; 1 = adjust seconds, 0 = adjust minutes
- `sec_tick` out 1: one-cycle count enable in RUN
- `adj_en` out 1: one-cycle step enable in ADJ
- `adj_sel` out 1: synchronized `select`
- `cnt_clr` out 1: one-cycle clear pulse to `count`
- `blink` out 1: blink phase for the adjusted digits
- `scan` out 2: display digit index
- `paused` out 1: pause flag
- `mode` out 2: 0 = RUN, 1 = PAUSED, 2 = ADJ

## Operation
- Synchronizers: each raw input passes through a 2-flop synchronizer. `adjust` and `select` are not debounced.
- Debouncer, one per button:
  - A counter increments each cycle the synchronized level differs from the debounced level and clears on any cycle of agreement.
  - When the counter reaches `DB_CYCLES`, the debounced level updates.
  - A rising edge of the debounced level gives a one-cycle event. Falling edges give no event.
- Mode FSM, with `paused` as a separate flag:
  - `mode` = ADJ whenever synchronized `adjust` != 0. Otherwise `mode` = PAUSED if `paused`, else RUN.
  - Leaving ADJ restores RUN or PAUSED from the unchanged `paused` flag.
- Pause event:
  - Toggles `paused` in RUN/PAUSED.
  - Is ignored in ADJ.
- Clear event:
  - Produces exactly one `cnt_clr` pulse in any mode.
  - Zeroes the 1 Hz divider and leaves `paused` unchanged.
  - A clear and a pause event in the same cycle both take effect.
- 1 Hz divider:
  - Counts only in RUN and holds its value in PAUSED and ADJ, so the fractional second is preserved.
  - On reaching `DIV_1HZ`-1 it wraps to 0 and pulses `sec_tick`.
- 2 Hz divider:
  - Counts only in ADJ and is zeroed otherwise.
  - On wrap it pulses `adj_en` and toggles `blink`. `blink` is forced to 0 outside ADJ.
- Scan divider: free-running. On wrap at `DIV_SCAN`-1, `scan` increments and wraps 3→0.
- `sec_tick` and `adj_en` are never high in the same cycle.

## Timing
- Reset: `reset` low at a rising edge forces the following on that edge, overriding everything, including mid-debounce or mid-tick:
  - outputs: `sec_tick`, `adj_en`, `cnt_clr`, `blink`, `paused` = 0; `scan` = 0; `mode` = RUN; `adj_sel` = 0
  - internal state: all dividers, debounce counters, debounced levels and synchronizers cleared
- After reset release, the first `sec_tick` asserts `DIV_1HZ` cycles after the first non-reset edge, then every `DIV_1HZ` cycles.
- Button latency: with the raw button held stable, the event takes effect (`paused` toggles or `cnt_clr` asserts) exactly `DB_CYCLES`+3 rising edges after the first edge that samples the raw level.
- Switch latency: a change on `adjust` or `select` reaches `mode`, `adj_sel` and the divider gating 3 edges after the first sampling edge.
- First `adj_en` occurs `DIV_2HZ` cycles after entering ADJ.
- On resume from PAUSED, the next `sec_tick` comes `DIV_1HZ` minus the already-elapsed count cycles later.

## Test plan
Parameters for all scenarios: `DIV_1HZ`=10, `DIV_2HZ`=5, `DIV_SCAN`=4, `DB_CYCLES`=3.
- Reset release with idle inputs → `sec_tick` on cycles 10, 20, 30; `scan` runs 0,1,2,3,0 changing every 4 cycles; `adj_en`, `cnt_clr`, `blink` stay 0; `mode`=0.
- `btn_pause` high for 8 cycles at 4 cycles after a tick → `paused`=1 and `mode`=1 on edge 6 after press start; no `sec_tick`. Second press → `mode`=0; next `sec_tick` exactly 6 cycles after resume.
- Bounce: `btn_pause` pattern 1,1,0,1,1,0 then held high → no toggle during the pattern; exactly one toggle, 6 edges after the final stable rise.
- `adjust`=2'b01, `select`=1 from RUN → `mode`=2 and `adj_sel`=1 after 3 edges; `adj_en` every 5 cycles; `blink` toggles on each; no `sec_tick`. `adjust`=0 → `mode`=0, `blink`=0.
- `btn_rst` press while PAUSED → exactly one `cnt_clr` pulse; `paused` stays 1. After resume, first `sec_tick` comes 10 cycles later.
- `reset` low for one cycle mid-ADJ with a debounce in progress → all outputs at reset values on that edge; that press produces no event.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: input synchronizers, button debouncers,
// run/pause/adjust mode tracking and the 1 Hz / 2 Hz / scan clock enables.
module stopwatch_ctrl #(
    parameter int unsigned DIV_1HZ   = 100_000_000,
    parameter int unsigned DIV_2HZ   = 50_000_000,
    parameter int unsigned DIV_SCAN  = 100_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_pause,
    input  logic       btn_rst,
    input  logic [1:0] adjust,
    input  logic       select,
    output logic       sec_tick,
    output logic       adj_en,
    output logic       adj_sel,
    output logic       cnt_clr,
    output logic       blink,
    output logic [1:0] scan,
    output logic       paused,
    output logic [1:0] mode
);

    localparam int unsigned W1  = (DIV_1HZ   > 1) ? $clog2(DIV_1HZ)   : 1;
    localparam int unsigned W2  = (DIV_2HZ   > 1) ? $clog2(DIV_2HZ)   : 1;
    localparam int unsigned WS  = (DIV_SCAN  > 1) ? $clog2(DIV_SCAN)  : 1;
    localparam int unsigned WDB = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJ    = 2'd2
    } mode_t;

    mode_t state, state_nxt;

    // Bit 0 carries the pause button, bit 1 the clear button.
    logic [1:0]     btn_s1, btn_s2;
    logic [1:0]     adj_s1, adj_s2;
    logic           sel_s1, sel_s2;
    logic [1:0]     db_lvl, db_prev;
    logic [WDB-1:0] db_cnt [2];
    logic [1:0]     btn_ev;
    logic           pause_ev, clr_ev, paused_nxt;
    logic [W1-1:0]  div_1hz;
    logic [W2-1:0]  div_2hz;
    logic [WS-1:0]  div_scan;

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            adj_s1 <= '0;
            adj_s2 <= '0;
            sel_s1 <= 1'b0;
            sel_s2 <= 1'b0;
        end else begin
            btn_s1 <= {btn_rst, btn_pause};
            btn_s2 <= btn_s1;
            adj_s1 <= adjust;
            adj_s2 <= adj_s1;
            sel_s1 <= select;
            sel_s2 <= sel_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            db_lvl  <= '0;
            db_prev <= '0;
            for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            db_prev <= db_lvl;
            for (int unsigned i = 0; i < 2; i++) begin
                if (btn_s2[i] != db_lvl[i]) begin
                    if (db_cnt[i] == WDB'(DB_CYCLES - 1)) begin
                        db_lvl[i] <= btn_s2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + WDB'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign btn_ev   = db_lvl & ~db_prev;
    assign pause_ev = btn_ev[0];
    assign clr_ev   = btn_ev[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= RUN;
            paused <= 1'b0;
        end else begin
            state  <= state_nxt;
            paused <= paused_nxt;
        end
    end

    // The mode register follows the post-toggle pause flag so both change on one edge.
    always_comb begin
        paused_nxt = paused ^ (pause_ev && (state != ADJ));
        if (adj_s2 != 2'b00)
            state_nxt = ADJ;
        else if (paused_nxt)
            state_nxt = PAUSED;
        else
            state_nxt = RUN;
    end

    always_comb begin
        mode = state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_1hz  <= '0;
            sec_tick <= 1'b0;
            cnt_clr  <= 1'b0;
        end else begin
            cnt_clr <= clr_ev;
            if (clr_ev) begin
                div_1hz  <= '0;
                sec_tick <= 1'b0;
            end else if (state == RUN) begin
                if (div_1hz == W1'(DIV_1HZ - 1)) begin
                    div_1hz  <= '0;
                    sec_tick <= 1'b1;
                end else begin
                    div_1hz  <= div_1hz + W1'(1);
                    sec_tick <= 1'b0;
                end
            end else begin
                sec_tick <= 1'b0;
            end
        end
    end

    // Blink is cleared by the upcoming mode so it drops on the same edge ADJ is left.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_2hz <= '0;
            adj_en  <= 1'b0;
            blink   <= 1'b0;
        end else begin
            adj_en <= 1'b0;
            if (state == ADJ) begin
                if (div_2hz == W2'(DIV_2HZ - 1)) begin
                    div_2hz <= '0;
                    adj_en  <= 1'b1;
                end else begin
                    div_2hz <= div_2hz + W2'(1);
                end
            end else begin
                div_2hz <= '0;
            end
            if (state_nxt != ADJ)
                blink <= 1'b0;
            else if (state == ADJ && div_2hz == W2'(DIV_2HZ - 1))
                blink <= ~blink;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_scan <= '0;
            scan     <= '0;
            adj_sel  <= 1'b0;
        end else begin
            adj_sel <= sel_s2;
            if (div_scan == WS'(DIV_SCAN - 1)) begin
                div_scan <= '0;
                scan     <= scan + 2'd1;
            end else begin
                div_scan <= div_scan + WS'(1);
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: reset/idle vector table, directed button and switch
// sequences, then randomized stimulus against a behavioural reference model.
module tb_stopwatch_ctrl;

    localparam int DIV1 = 10;
    localparam int DIV2 = 5;
    localparam int DIVS = 4;
    localparam int DB   = 3;

    logic       clk;
    logic       reset;
    logic       btn_pause;
    logic       btn_rst;
    logic [1:0] adjust;
    logic       select;
    logic       sec_tick, adj_en, adj_sel, cnt_clr, blink, paused;
    logic [1:0] scan, mode;

    stopwatch_ctrl #(
        .DIV_1HZ  (DIV1),
        .DIV_2HZ  (DIV2),
        .DIV_SCAN (DIVS),
        .DB_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_pause(btn_pause),
        .btn_rst  (btn_rst),
        .adjust   (adjust),
        .select   (select),
        .sec_tick (sec_tick),
        .adj_en   (adj_en),
        .adj_sel  (adj_sel),
        .cnt_clr  (cnt_clr),
        .blink    (blink),
        .scan     (scan),
        .paused   (paused),
        .mode     (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       rst_n;
        logic       bp;
        logic       br;
        logic [1:0] adj;
        logic       sel;
    } in_t;

    in_t        hist[$];
    bit         q_p[$], q_r[$];
    bit         db_p, db_r, pend_p, pend_r, m_paused;
    int         m_mode, run_el, adj_el, k;
    logic [9:0] exp_out;

    function automatic bit all_ne(input bit q[$], input bit lvl);
        foreach (q[i]) if (q[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input in_t x);
        in_t s;
        bit  ev_p, ev_r, new_p, e_sec, e_adj, e_blink;
        int  mode_n;
        if (!x.rst_n) begin
            hist.delete(); q_p.delete(); q_r.delete();
            db_p = 0; db_r = 0; pend_p = 0; pend_r = 0; m_paused = 0;
            m_mode = 0; run_el = 0; adj_el = 0; k = 0; exp_out = '0;
            return;
        end
        s = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
        hist.push_back(x);
        if (hist.size() > 2) void'(hist.pop_front());
        k++;
        ev_p = pend_p;
        ev_r = pend_r;
        // a level is accepted once DB consecutive synchronized samples oppose it
        q_p.push_back(s.bp);
        if (q_p.size() > DB) void'(q_p.pop_front());
        pend_p = 0;
        if (q_p.size() == DB && all_ne(q_p, db_p)) begin
            db_p = ~db_p; pend_p = db_p; q_p.delete();
        end
        q_r.push_back(s.br);
        if (q_r.size() > DB) void'(q_r.pop_front());
        pend_r = 0;
        if (q_r.size() == DB && all_ne(q_r, db_r)) begin
            db_r = ~db_r; pend_r = db_r; q_r.delete();
        end
        new_p  = m_paused ^ (ev_p && m_mode != 2);
        mode_n = (s.adj != 0) ? 2 : (new_p ? 1 : 0);
        e_sec = 0;
        if (ev_r) run_el = 0;
        else if (m_mode == 0) begin
            run_el++;
            if (run_el == DIV1) begin e_sec = 1; run_el = 0; end
        end
        e_adj = 0;
        if (m_mode == 2) begin
            adj_el++;
            e_adj = (adj_el % DIV2) == 0;
        end else adj_el = 0;
        e_blink = (mode_n == 2) ? bit'((adj_el / DIV2) % 2) : 1'b0;
        exp_out = {e_sec, e_adj, s.sel, ev_r, e_blink, 2'((k / DIVS) % 4), new_p, 2'(mode_n)};
        m_paused = new_p;
        m_mode   = mode_n;
    endtask

    task automatic cyc();
        in_t x;
        x.rst_n = reset; x.bp = btn_pause; x.br = btn_rst; x.adj = adjust; x.sel = select;
        @(posedge clk);
        #1;
        model_step(x);
        chk("model", {6'b0, sec_tick, adj_en, adj_sel, cnt_clr, blink, scan, paused, mode},
            {6'b0, exp_out});
    endtask

    task automatic wait_tick();
        bit found = 0;
        for (int i = 0; i < 25 && !found; i++) begin
            cyc();
            if (sec_tick === 1'b1) found = 1;
        end
        chk("wait_tick", {15'b0, found}, 16'h1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic       bp;
        logic       br;
        logic [1:0] adj;
        logic       sel;
        logic       e_tick;
        logic       e_adj_en;
        logic       e_clr;
        logic       e_blink;
        logic [1:0] e_scan;
        logic       e_paused;
        logic [1:0] e_mode;
    } vec_t;

    vec_t tbl[31];

    initial begin
        #500000;
        $display("FAIL timeout: summary not reached in time");
        $fatal(1);
    end

    initial begin
        int hold_p, hold_r;
        int pat[6];
        reset = 1'b0; btn_pause = 1'b0; btn_rst = 1'b0; adjust = 2'b00; select = 1'b0;
        pat = '{1, 1, 0, 1, 1, 0};

        for (int i = 0; i < 31; i++) begin
            tbl[i].rst_n    = (i != 0);
            tbl[i].bp       = 1'b0;
            tbl[i].br       = 1'b0;
            tbl[i].adj      = 2'b00;
            tbl[i].sel      = 1'b0;
            tbl[i].e_tick   = (i != 0) && (i % 10 == 0);
            tbl[i].e_adj_en = 1'b0;
            tbl[i].e_clr    = 1'b0;
            tbl[i].e_blink  = 1'b0;
            tbl[i].e_scan   = 2'((i / 4) % 4);
            tbl[i].e_paused = 1'b0;
            tbl[i].e_mode   = 2'd0;
        end

        // reset, then idle: ticks on edges 10/20/30, scan advancing every 4 edges
        for (int i = 0; i < 31; i++) begin
            reset = tbl[i].rst_n; btn_pause = tbl[i].bp; btn_rst = tbl[i].br;
            adjust = tbl[i].adj; select = tbl[i].sel;
            cyc();
            chk($sformatf("table%0d", i),
                {7'b0, sec_tick, adj_en, cnt_clr, blink, scan, paused, mode},
                {7'b0, tbl[i].e_tick, tbl[i].e_adj_en, tbl[i].e_clr, tbl[i].e_blink,
                 tbl[i].e_scan, tbl[i].e_paused, tbl[i].e_mode});
        end

        // pause lands 4 cycles after a tick; resume yields a tick 6 cycles later
        wait_tick();
        repeat (8) cyc();
        btn_pause = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (i == 5) chk("pause_early", {15'b0, paused}, 16'h0);
            if (i == 6) chk("pause_set", {14'b0, paused, 1'b0} | {14'b0, mode}, {14'b0, 2'd1} | 16'h2);
        end
        btn_pause = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk("paused_no_tick", {14'b0, sec_tick, paused}, 16'h1);
        end
        btn_pause = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 9) btn_pause = 1'b0;
            cyc();
            if (i == 5) chk("resume_early", {14'b0, mode}, 16'h1);
            if (i == 6) chk("resume_mode", {14'b0, mode}, 16'h0);
            if (i > 6 && i < 12) chk("resume_gap", {15'b0, sec_tick}, 16'h0);
            if (i == 12) chk("resume_tick", {15'b0, sec_tick}, 16'h1);
        end
        repeat (8) cyc();

        // bounce: no toggle during the pattern, one toggle 6 edges after the stable rise
        for (int i = 0; i < 6; i++) begin
            btn_pause = pat[i][0];
            cyc();
            chk("bounce_hold", {15'b0, paused}, 16'h0);
        end
        btn_pause = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            cyc();
            chk($sformatf("bounce_edge%0d", j), {15'b0, paused}, {15'b0, (j == 6)});
        end
        btn_pause = 1'b0;
        repeat (8) cyc();

        // clear while paused: one cnt_clr, paused held, full second after resume
        btn_rst = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            if (j == 9) btn_rst = 1'b0;
            cyc();
            chk($sformatf("clr_edge%0d", j), {14'b0, cnt_clr, paused}, {14'b0, (j == 6), 1'b1});
        end
        btn_pause = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            if (j == 9) btn_pause = 1'b0;
            cyc();
            if (j == 6) chk("clr_resume", {14'b0, mode}, 16'h0);
            if (j > 6) chk($sformatf("clr_tick%0d", j), {15'b0, sec_tick}, {15'b0, (j == 16)});
        end

        // adjust mode: step every 5 cycles with blink toggling, then exit
        adjust = 2'b01; select = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            if (j == 20) adjust = 2'b00;
            cyc();
            if (j == 2) chk("adj_enter_early", {14'b0, mode}, 16'h0);
            if (j == 3) chk("adj_enter", {13'b0, mode, adj_sel}, {13'b0, 2'd2, 1'b1});
            chk("adj_no_tick", {15'b0, sec_tick}, 16'h0);
            if (j <= 21) begin
                chk($sformatf("adj_en%0d", j), {15'b0, adj_en},
                    {15'b0, (j == 8 || j == 13 || j == 18)});
                chk($sformatf("blink%0d", j), {15'b0, blink},
                    {15'b0, ((j >= 8 && j < 13) || j >= 18)});
            end
            if (j == 21) chk("adj_exit_early", {14'b0, mode}, 16'h2);
            if (j == 22) chk("adj_exit", {13'b0, mode, blink}, 16'h0);
        end

        // reset mid-adjust with a clear press still debouncing
        adjust = 2'b01;
        repeat (4) cyc();
        btn_rst = 1'b1;
        repeat (4) cyc();
        reset = 1'b0; btn_rst = 1'b0; adjust = 2'b00; select = 1'b0;
        cyc();
        chk("reset_mid", {6'b0, sec_tick, adj_en, adj_sel, cnt_clr, blink, scan, paused, mode}, 16'h0);
        reset = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            cyc();
            chk("reset_no_event", {14'b0, cnt_clr, paused}, 16'h0);
        end

        // randomized stimulus, checked every cycle by the model inside cyc()
        hold_p = 0; hold_r = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold_p == 0) begin
                btn_pause = 1'($urandom_range(0, 1)); hold_p = $urandom_range(1, 10);
            end else hold_p--;
            if (hold_r == 0) begin
                btn_rst = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 12);
            end else hold_r--;
            if ($urandom_range(0, 39) == 0)
                adjust = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 29) == 0) select = ~select;
            reset = ($urandom_range(0, 399) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
